mac_result_fifo: RTL and testbench

- Downstream stage of the pipelined saturating MAC.
- Captures every f sample qualified by the MAC's valid_out into a small first-word-fall-through FIFO and presents it on a ready/valid stream to the result sink.
- The MAC cannot stall, so the block never back-pressures it. Samples that arrive while the FIFO is full are dropped and counted.
- Tracks saturated results, overflow drops and peak occupancy for debug.

---
 rtl/mac_result_fifo.sv | 108 ++++++++++
 tb/tb_mac_result_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_fifo.sv
// First-word-fall-through result FIFO behind the saturating MAC: never stalls the MAC,
// drops and counts samples that arrive while full, and keeps debug statistics.
module mac_result_fifo #(
  parameter int DATA_W = 28,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [DATA_W-1:0]   f_in,
  input  logic                       valid_in,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       out_sat,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       clr_stats,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           overflow_cnt,
  output logic [CNT_W-1:0]           sat_cnt,
  output logic [$clog2(DEPTH):0]     peak_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic is_sat(input logic signed [DATA_W-1:0] f);
    logic signed [DATA_W-1:0] pos_max;
    logic signed [DATA_W-1:0] neg_max;
    pos_max = {1'b0, {(DATA_W-1){1'b1}}};
    neg_max = {1'b1, {(DATA_W-1){1'b0}}};
    return (f == pos_max) || (f == neg_max);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Each entry carries its sat flag in the MSB so out_sat needs no recompute.
  logic [DATA_W:0]    mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [LW-1:0]      peak_q, peak_d;
  logic [CNT_W-1:0]   ovf_q, ovf_d;
  logic [CNT_W-1:0]   satc_q, satc_d;
  logic               in_sat, push, pop, drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == DEPTH_L);

  always_comb begin
    in_sat   = is_sat(f_in);
    pop      = !empty && out_ready;
    push     = valid_in && (!full || pop);
    drop     = valid_in && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    ovf_d    = ovf_q;
    if (clr_stats)         ovf_d = '0;
    else if (drop)         ovf_d = sat_inc(ovf_q);
    satc_d   = satc_q;
    if (clr_stats)                 satc_d = '0;
    else if (valid_in && in_sat)   satc_d = sat_inc(satc_q);
    // Clearing re-seeds the peak from the occupancy that is about to be current.
    if (clr_stats)                 peak_d = level_d;
    else if (level_d > peak_q)     peak_d = level_d;
    else                           peak_d = peak_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      peak_q   <= '0;
      ovf_q    <= '0;
      satc_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      peak_q   <= peak_d;
      ovf_q    <= ovf_d;
      satc_q   <= satc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_sat, f_in};
  end

  // Head outputs come from registered state only; empty forces them to zero.
  assign out_valid    = !empty;
  assign out_data     = empty ? '0 : $signed(mem_q[rd_ptr_q][DATA_W-1:0]);
  assign out_sat      = !empty && mem_q[rd_ptr_q][DATA_W];
  assign level        = level_q;
  assign peak_level   = peak_q;
  assign overflow_cnt = ovf_q;
  assign sat_cnt      = satc_q;

endmodule

// File: tb/tb_mac_result_fifo.sv
// Randomised bench for mac_result_fifo: a queue-based reference model is compared on
// every negedge, with directed sequences and literal expectations around it.
module tb_mac_result_fifo;

  localparam int DW    = 28;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [DW-1:0] f_in = '0;
  logic valid_in = 1'b0, out_ready = 1'b0, clr_stats = 1'b0;

  logic signed [DW-1:0] out_data, out_data4;
  logic out_sat, out_valid, full, empty;
  logic out_sat4, out_valid4, full4, empty4;
  logic [3:0] level, peak_level, level4, peak_level4;
  logic [15:0] overflow_cnt, sat_cnt;
  logic [3:0]  overflow_cnt4, sat_cnt4;

  always #5 clk = ~clk;

  mac_result_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .f_in(f_in), .valid_in(valid_in),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
    .clr_stats(clr_stats), .level(level), .full(full), .empty(empty),
    .overflow_cnt(overflow_cnt), .sat_cnt(sat_cnt), .peak_level(peak_level)
  );

  mac_result_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .f_in(f_in), .valid_in(valid_in),
    .out_data(out_data4), .out_sat(out_sat4), .out_valid(out_valid4), .out_ready(out_ready),
    .clr_stats(clr_stats), .level(level4), .full(full4), .empty(empty4),
    .overflow_cnt(overflow_cnt4), .sat_cnt(sat_cnt4), .peak_level(peak_level4)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of {sat, data} plus plain integer statistics.
  logic [DW:0] mq[$];
  int m_ovf16 = 0, m_sat16 = 0, m_ovf4 = 0, m_sat4 = 0, m_peak = 0;
  bit mpop, mpush, mdrop, msat;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ovf16 = 0; m_sat16 = 0; m_ovf4 = 0; m_sat4 = 0; m_peak = 0;
    end else begin
      mpop  = (mq.size() != 0) && out_ready;
      mpush = valid_in && (mq.size() < DEPTH || mpop);
      mdrop = valid_in && !mpush;
      msat  = valid_in && (f_in == 28'sh7FFFFFF || f_in == 28'sh8000000);
      if (mpop)  void'(mq.pop_front());
      if (mpush) mq.push_back({msat, f_in});
      if (clr_stats) begin
        m_ovf16 = 0; m_sat16 = 0; m_ovf4 = 0; m_sat4 = 0;
        m_peak = mq.size();
      end else begin
        if (mdrop) begin
          m_ovf16 = (m_ovf16 < 65535) ? m_ovf16 + 1 : m_ovf16;
          m_ovf4  = (m_ovf4 < 15) ? m_ovf4 + 1 : m_ovf4;
        end
        if (msat) begin
          m_sat16 = (m_sat16 < 65535) ? m_sat16 + 1 : m_sat16;
          m_sat4  = (m_sat4 < 15) ? m_sat4 + 1 : m_sat4;
        end
        if (mq.size() > m_peak) m_peak = mq.size();
      end
    end
  end

  task automatic cmp_all();
    int n;
    logic [DW:0] head;
    logic signed [DW-1:0] ed;
    logic es;
    n = mq.size();
    head = (n != 0) ? mq[0] : '0;
    ed = head[DW-1:0];
    es = head[DW];
    check("level", longint'(level), longint'(n));
    check("out_valid", longint'(out_valid), longint'(n != 0));
    check("empty", longint'(empty), longint'(n == 0));
    check("full", longint'(full), longint'(n == DEPTH));
    check("out_data", longint'(out_data), longint'(ed));
    check("out_sat", longint'(out_sat), longint'(es));
    check("overflow_cnt", longint'(overflow_cnt), longint'(m_ovf16));
    check("sat_cnt", longint'(sat_cnt), longint'(m_sat16));
    check("peak_level", longint'(peak_level), longint'(m_peak));
    check("level4", longint'(level4), longint'(n));
    check("out_valid4", longint'(out_valid4), longint'(n != 0));
    check("empty4", longint'(empty4), longint'(n == 0));
    check("full4", longint'(full4), longint'(n == DEPTH));
    check("out_data4", longint'(out_data4), longint'(ed));
    check("out_sat4", longint'(out_sat4), longint'(es));
    check("overflow_cnt4", longint'(overflow_cnt4), longint'(m_ovf4));
    check("sat_cnt4", longint'(sat_cnt4), longint'(m_sat4));
    check("peak_level4", longint'(peak_level4), longint'(m_peak));
  endtask

  always @(negedge clk) cmp_all();

  task automatic drive(input bit v, input int d, input bit r, input bit c);
    valid_in = v; f_in = DW'(d); out_ready = r; clr_stats = c;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step(input bit v, input int d, input bit r, input bit c);
    drive(v, d, r, c); tick();
  endtask

  int exp_tail[8] = '{2, 3, 4, 5, 6, 7, 8, 100};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", longint'(level), 0);
    check("rst_empty", longint'(empty), 1);
    check("rst_full", longint'(full), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_data", longint'(out_data), 0);
    check("rst_ovf", longint'(overflow_cnt), 0);
    check("rst_peak", longint'(peak_level), 0);
    reset = 1'b1;
    step(0, 0, 0, 0); step(0, 0, 1, 0);
    check("idle_empty", longint'(empty), 1);
    check("idle_sat", longint'(out_sat), 0);

    for (int i = 1; i <= 8; i++) step(1, i, 0, 0);
    check("fill_level", longint'(level), 8);
    check("fill_full", longint'(full), 1);
    check("fill_peak", longint'(peak_level), 8);
    check("fill_head", longint'(out_data), 1);
    step(1, 9, 0, 0);
    check("drop_ovf", longint'(overflow_cnt), 1);
    check("drop_level", longint'(level), 8);
    for (int i = 1; i <= 8; i++) begin
      check("drain_data", longint'(out_data), longint'(i));
      step(0, 0, 1, 0);
    end
    check("drain_empty", longint'(empty), 1);
    check("drain_valid", longint'(out_valid), 0);

    for (int i = 1; i <= 8; i++) step(1, i, 0, 0);
    step(1, 100, 1, 0);
    check("fullpop_level", longint'(level), 8);
    check("fullpop_head", longint'(out_data), 2);
    check("fullpop_ovf", longint'(overflow_cnt), 1);
    for (int i = 0; i < 8; i++) begin
      check("tail_data", longint'(out_data), longint'(exp_tail[i]));
      step(0, 0, 1, 0);
    end
    check("tail_empty", longint'(empty), 1);

    step(1, 28'h7FFFFFF, 0, 0);
    step(1, 28'h8000000, 0, 0);
    step(1, 5, 0, 0);
    check("sat_cnt3", longint'(sat_cnt), 2);
    check("sat_level", longint'(level), 3);
    check("sat_head0", longint'(out_sat), 1);
    check("sat_data0", longint'(out_data), 134217727);
    step(0, 0, 1, 0);
    check("sat_head1", longint'(out_sat), 1);
    check("sat_data1", longint'(out_data), -134217728);
    step(0, 0, 1, 0);
    check("sat_head2", longint'(out_sat), 0);
    check("sat_data2", longint'(out_data), 5);
    step(0, 0, 1, 0);

    step(0, 0, 0, 1);
    check("clr_ovf", longint'(overflow_cnt), 0);
    check("clr_sat", longint'(sat_cnt), 0);
    check("clr_peak", longint'(peak_level), 0);
    for (int i = 0; i < 8; i++) step(1, 10 + i, 0, 0);
    step(1, 28'h7FFFFFF, 0, 0);
    step(1, 28'h8000000, 0, 0);
    step(1, 5, 0, 0);
    check("fullsat_sat", longint'(sat_cnt), 2);
    check("fullsat_ovf", longint'(overflow_cnt), 3);
    check("fullsat_head", longint'(out_data), 10);
    for (int i = 0; i < 20; i++) step(1, 1000, 0, 0);
    check("ovf16_23", longint'(overflow_cnt), 23);
    check("ovf4_stick", longint'(overflow_cnt4), 15);
    step(1, 1000, 0, 1);
    check("clrwin_ovf", longint'(overflow_cnt), 0);
    check("clrwin_ovf4", longint'(overflow_cnt4), 0);
    check("clrwin_peak", longint'(peak_level), 8);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

    drive(1, -7, 1, 0);
    #1;
    check("nobypass_valid", longint'(out_valid), 0);
    check("nobypass_data", longint'(out_data), 0);
    tick();
    check("lat_valid", longint'(out_valid), 1);
    check("lat_data", longint'(out_data), -7);
    step(0, 0, 1, 0);

    step(1, 28'h8000000, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 50 + i, 0, 0);
    check("mid_level", longint'(level), 5);
    check("mid_sat", longint'(sat_cnt), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_level", longint'(level), 0);
    check("arst_valid", longint'(out_valid), 0);
    check("arst_sat", longint'(sat_cnt), 0);
    check("arst_peak", longint'(peak_level), 0);
    check("arst_empty", longint'(empty), 1);
    drive(0, 0, 0, 0);
    @(posedge clk); #1 reset = 1'b1;

    for (int k = 0; k < 20000; k++) begin
      int vp, rp, sel, d;
      case ((k / 2500) % 4)
        0: begin vp = 80; rp = 30; end
        1: begin vp = 30; rp = 80; end
        2: begin vp = 95; rp = 90; end
        default: begin vp = 60; rp = 60; end
      endcase
      sel = $urandom_range(0, 15);
      d = (sel == 0) ? 28'h7FFFFFF : (sel == 1) ? 28'h8000000 : int'($urandom);
      step($urandom_range(0, 99) < vp, d, $urandom_range(0, 99) < rp,
           $urandom_range(0, 199) == 0);
    end
    drive(0, 0, 0, 0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
